// File: rtl/float64_pkg.sv
// Shared float64 decode definitions: class encodings, flag bits, exponent limits, FSM states.
package float64_pkg;

    localparam logic [2:0] CLS_ZERO    = 3'd0;
    localparam logic [2:0] CLS_SUBNORM = 3'd1;
    localparam logic [2:0] CLS_NORMAL  = 3'd2;
    localparam logic [2:0] CLS_INF     = 3'd3;
    localparam logic [2:0] CLS_QNAN    = 3'd4;
    localparam logic [2:0] CLS_SNAN    = 3'd5;

    localparam logic [31:0] FLAG_INVALID = 32'h10;
    localparam int          EXP_BIAS     = 1023;
    localparam logic [10:0] EXP_MAX      = 11'd2047;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_NORM,
        ST_DONE
    } state_t;

endpackage

// File: rtl/float64_classify.sv
// Combinational binary64 classifier: biased exponent and fraction fields to class code.
module float64_classify
    import float64_pkg::*;
(
    input  logic [10:0] exp_f,
    input  logic [51:0] frac,
    output logic [2:0]  cls
);

    always_comb begin
        cls = CLS_NORMAL;
        if (exp_f == 11'd0) begin
            cls = (frac == 52'd0) ? CLS_ZERO : CLS_SUBNORM;
        end else if (exp_f == EXP_MAX) begin
            // Quiet bit is the fraction MSB; a NaN without it is signalling.
            if (frac == 52'd0)  cls = CLS_INF;
            else if (frac[51])  cls = CLS_QNAN;
            else                cls = CLS_SNAN;
        end
    end

endmodule

// File: rtl/unpack_float64.sv
// Unpacks a binary64 operand into sign/exponent/significand with class and flags; ap_ctrl_hs handshake.
// Build option UNPACK_F64_DAZ_EN: subnormal inputs are flushed to signed zero instead of normalised.
module unpack_float64
    import float64_pkg::*;
#(
    parameter int EXP_W = 13,
    parameter int SIG_W = 64
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             ap_ready,
    input  logic [63:0]      a,
    output logic             zSign,
    output logic [EXP_W-1:0] zExp,
    output logic [SIG_W-1:0] zSig,
    output logic [2:0]       zClass,
    input  logic [31:0]      float_exception_flag_i,
    output logic [31:0]      float_exception_flag_o,
    output logic             float_exception_flag_o_ap_vld
);

`ifdef UNPACK_F64_DAZ_EN
    localparam bit DAZ_EN = 1'b1;
`else
    localparam bit DAZ_EN = 1'b0;
`endif

    state_t state, state_nxt;

    logic [63:0]      a_q;
    logic [31:0]      flag_q;
    logic [52:0]      sig53;
    logic [EXP_W-1:0] nexp;
    logic             vld_q;

    logic [10:0] exp_f;
    logic [51:0] frac;
    logic [2:0]  cls;
    logic [2:0]  cls_eff;
    logic [52:0] sig_shl;
    logic        to_norm;

    assign exp_f   = a_q[62:52];
    assign frac    = a_q[51:0];
    assign sig_shl = {sig53[51:0], 1'b0};

    float64_classify u_classify (
        .exp_f (exp_f),
        .frac  (frac),
        .cls   (cls)
    );

    assign cls_eff = (DAZ_EN && cls == CLS_SUBNORM) ? CLS_ZERO : cls;
    assign to_norm = (cls_eff == CLS_SUBNORM);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (ap_start) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = to_norm ? ST_NORM : ST_DONE;
            // Exit on the edge that brings the leading one into bit 52, so latency is 2+s.
            ST_NORM:   if (sig_shl[52]) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state                  <= ST_IDLE;
            a_q                    <= '0;
            flag_q                 <= '0;
            sig53                  <= '0;
            nexp                   <= '0;
            vld_q                  <= 1'b0;
            zSign                  <= 1'b0;
            zExp                   <= '0;
            zSig                   <= '0;
            zClass                 <= CLS_ZERO;
            float_exception_flag_o <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (ap_start) begin
                        a_q    <= a;
                        flag_q <= float_exception_flag_i;
                    end
                end
                ST_DECODE: begin
                    sig53 <= {1'b0, frac};
                    nexp  <= '0;
                    if (!to_norm) begin
                        zSign                  <= a_q[63];
                        zClass                 <= cls_eff;
                        vld_q                  <= (cls_eff == CLS_SNAN);
                        float_exception_flag_o <= (cls_eff == CLS_SNAN) ? (flag_q | FLAG_INVALID)
                                                                        : flag_q;
                        case (cls_eff)
                            CLS_NORMAL: begin
                                zExp <= EXP_W'(exp_f - 11'd1);
                                zSig <= {1'b0, 1'b1, frac, 10'b0};
                            end
                            CLS_INF, CLS_QNAN, CLS_SNAN: begin
                                zExp <= EXP_W'(EXP_MAX);
                                zSig <= {2'b0, frac, 10'b0};
                            end
                            default: begin
                                zExp <= '0;
                                zSig <= '0;
                            end
                        endcase
                    end
                end
                ST_NORM: begin
                    sig53 <= sig_shl;
                    nexp  <= nexp - 1'b1;
                    if (sig_shl[52]) begin
                        zSign                  <= a_q[63];
                        zClass                 <= CLS_SUBNORM;
                        zExp                   <= nexp - 1'b1;
                        zSig                   <= {1'b0, sig_shl, 10'b0};
                        vld_q                  <= 1'b0;
                        float_exception_flag_o <= flag_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ap_idle  = (state == ST_IDLE);
    assign ap_done  = (state == ST_DONE);
    assign ap_ready = ap_done;
    assign float_exception_flag_o_ap_vld = ap_done & vld_q;

endmodule

// File: tb/tb_unpack_float64.sv
// Directed-vector bench for unpack_float64: classes, latency, flags, reset abort, back-to-back starts.
module tb_unpack_float64;
    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done, ap_idle, ap_ready;
    logic [63:0] a;
    logic        zSign;
    logic [12:0] zExp;
    logic [63:0] zSig;
    logic [2:0]  zClass;
    logic [31:0] flag_i, flag_o;
    logic        flag_vld;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    unpack_float64 dut (
        .ap_clk                        (ap_clk),
        .ap_rst                        (ap_rst),
        .ap_start                      (ap_start),
        .ap_done                       (ap_done),
        .ap_idle                       (ap_idle),
        .ap_ready                      (ap_ready),
        .a                             (a),
        .zSign                         (zSign),
        .zExp                          (zExp),
        .zSig                          (zSig),
        .zClass                        (zClass),
        .float_exception_flag_i        (flag_i),
        .float_exception_flag_o        (flag_o),
        .float_exception_flag_o_ap_vld (flag_vld)
    );

    // Launches one operation; returns latency (start edge to ap_done) or -1 on timeout.
    task automatic run_op(input logic [63:0] av, input logic [31:0] fl,
                          output int lat, output logic vld, output logic rdy);
        @(negedge ap_clk);
        a = av; flag_i = fl; ap_start = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        ap_start = 1'b0;
        lat = -1; vld = 1'b0; rdy = 1'b0;
        for (int n = 0; n <= 100; n++) begin
            if (ap_done) begin
                lat = n + 1; vld = flag_vld; rdy = ap_ready;
                break;
            end
            @(negedge ap_clk);
        end
    endtask

    task automatic test_reset();
        ap_rst = 1'b1; ap_start = 1'b0; a = '0; flag_i = '0;
        repeat (3) @(negedge ap_clk);
        vectors++; if ({ap_idle, ap_done, ap_ready, flag_vld} !== 4'b1000) begin
            miscompares++; $display("FAIL reset_ctrl got %b want 1000", {ap_idle, ap_done, ap_ready, flag_vld}); end
        vectors++; if ({zSign, zExp, zSig, zClass, flag_o} !== '0) begin
            miscompares++; $display("FAIL reset_data got %h %h %h %h %h want 0", zSign, zExp, zSig, zClass, flag_o); end
        ap_rst = 1'b0;
        @(negedge ap_clk);
    endtask

    task automatic test_normal();
        int lat; logic vld, rdy;
        run_op(64'h3FF0000000000000, 32'h0000_0004, lat, vld, rdy);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL normal_lat got %0d want 2", lat); end
        vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL normal_ready got %b want 1", rdy); end
        vectors++; if (zSign !== 1'b0 || zExp !== 13'h03FE || zSig !== 64'h4000000000000000) begin
            miscompares++; $display("FAIL normal_val got %b %h %h want 0 03fe 4000000000000000", zSign, zExp, zSig); end
        vectors++; if (zClass !== 3'd2 || vld !== 1'b0 || flag_o !== 32'h4) begin
            miscompares++; $display("FAIL normal_cls got cls %0d vld %b flag %h want 2 0 00000004", zClass, vld, flag_o); end
        @(negedge ap_clk);
        vectors++; if (ap_done !== 1'b0 || ap_idle !== 1'b1 || zExp !== 13'h03FE) begin
            miscompares++; $display("FAIL normal_hold got done %b idle %b exp %h want 0 1 03fe", ap_done, ap_idle, zExp); end
    endtask

    task automatic test_subnormal();
        int lat; logic vld, rdy;
        run_op(64'h0000000000000001, 32'h0, lat, vld, rdy);
`ifdef UNPACK_F64_DAZ_EN
        vectors++; if (lat !== 2 || zClass !== 3'd0 || zExp !== 13'h0 || zSig !== 64'h0) begin
            miscompares++; $display("FAIL daz got lat %0d cls %0d exp %h sig %h want 2 0 0 0", lat, zClass, zExp, zSig); end
`else
        vectors++; if (lat !== 54) begin miscompares++; $display("FAIL subnorm_lat got %0d want 54", lat); end
        vectors++; if (zExp !== 13'h1FCC || zSig !== 64'h4000000000000000 || zClass !== 3'd1) begin
            miscompares++; $display("FAIL subnorm_val got %h %h %0d want 1fcc 4000000000000000 1", zExp, zSig, zClass); end
        // Top fraction bit set: one shift, zExp=-1.
        run_op(64'h8008000000000000, 32'h0, lat, vld, rdy);
        vectors++; if (lat !== 3 || zSign !== 1'b1 || zExp !== 13'h1FFF || zSig !== 64'h4000000000000000) begin
            miscompares++; $display("FAIL subnorm_top got lat %0d %b %h %h want 3 1 1fff 4000000000000000", lat, zSign, zExp, zSig); end
`endif
        vectors++; if (vld !== 1'b0) begin miscompares++; $display("FAIL subnorm_vld got %b want 0", vld); end
    endtask

    task automatic test_nan();
        int lat; logic vld, rdy;
        run_op(64'h7FF0000000000001, 32'h01, lat, vld, rdy);
        vectors++; if (zClass !== 3'd5 || zExp !== 13'h07FF || zSig !== 64'h400) begin
            miscompares++; $display("FAIL snan_val got %0d %h %h want 5 07ff 400", zClass, zExp, zSig); end
        vectors++; if (flag_o !== 32'h11 || vld !== 1'b1 || lat !== 2) begin
            miscompares++; $display("FAIL snan_flag got %h vld %b lat %0d want 11 1 2", flag_o, vld, lat); end
        run_op(64'h7FF8000000000000, 32'h01, lat, vld, rdy);
        vectors++; if (zClass !== 3'd4 || zSig !== 64'h2000000000000000 || flag_o !== 32'h01 || vld !== 1'b0) begin
            miscompares++; $display("FAIL qnan got %0d %h %h %b want 4 2000000000000000 1 0", zClass, zSig, flag_o, vld); end
    endtask

    task automatic test_zero_inf();
        int lat; logic vld, rdy;
        run_op(64'h8000000000000000, 32'h0, lat, vld, rdy);
        vectors++; if (zSign !== 1'b1 || zClass !== 3'd0 || zExp !== 13'h0 || zSig !== 64'h0) begin
            miscompares++; $display("FAIL neg_zero got %b %0d %h %h want 1 0 0 0", zSign, zClass, zExp, zSig); end
        run_op(64'hFFF0000000000000, 32'h0, lat, vld, rdy);
        vectors++; if (zSign !== 1'b1 || zClass !== 3'd3 || zExp !== 13'h07FF || zSig !== 64'h0) begin
            miscompares++; $display("FAIL neg_inf got %b %0d %h %h want 1 3 07ff 0", zSign, zClass, zExp, zSig); end
        // Largest finite: E=2046.
        run_op(64'h7FEFFFFFFFFFFFFF, 32'h0, lat, vld, rdy);
        vectors++; if (zClass !== 3'd2 || zExp !== 13'h07FD || zSig !== 64'h7FFFFFFFFFFFFC00) begin
            miscompares++; $display("FAIL max_fin got %0d %h %h want 2 07fd 7ffffffffffffc00", zClass, zExp, zSig); end
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        @(negedge ap_clk);
        a = 64'h0000000000000001; flag_i = 32'h0; ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (10) @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        vectors++; if (ap_idle !== 1'b1 || ap_done !== 1'b0 || zSig !== 64'h0 || zExp !== 13'h0) begin
            miscompares++; $display("FAIL abort_state got idle %b done %b sig %h exp %h want 1 0 0 0", ap_idle, ap_done, zSig, zExp); end
        ap_rst = 1'b0;
        repeat (60) begin
            @(negedge ap_clk);
            if (ap_done) seen++;
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL abort_nodone got %0d pulses want 0", seen); end
    endtask

    task automatic test_back_to_back();
        int d0 = -1, d1 = -1;
        logic [12:0] e0 = '0, e1 = '0;
        @(negedge ap_clk);
        a = 64'h3FF0000000000000; flag_i = 32'h0; ap_start = 1'b1;
        @(negedge ap_clk);
        a = 64'h4000000000000000;
        for (int n = 0; n < 20 && d1 < 0; n++) begin
            if (ap_done) begin
                if (d0 < 0) begin d0 = cyc; e0 = zExp; end
                else begin d1 = cyc; e1 = zExp; ap_start = 1'b0; end
            end
            @(negedge ap_clk);
        end
        ap_start = 1'b0;
        vectors++; if (d0 < 0 || d1 < 0 || d1 - d0 !== 3) begin
            miscompares++; $display("FAIL b2b_spacing got %0d want 3", d1 - d0); end
        vectors++; if (e0 !== 13'h03FE || e1 !== 13'h03FF) begin
            miscompares++; $display("FAIL b2b_vals got %h %h want 03fe 03ff", e0, e1); end
        repeat (3) @(negedge ap_clk);
        vectors++; if (ap_idle !== 1'b1) begin miscompares++; $display("FAIL b2b_idle got %b want 1", ap_idle); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_subnormal();
        test_nan();
        test_zero_inf();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
